// File: rtl/icache_pkg.sv
// icache_pkg: shared widths, FSM encoding and word select for the icache controller
package icache_pkg;
  localparam int ADDR_W = 14;
  localparam int LINE_W = 64;
  localparam int WORD_W = 16;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MEM_RD = 2'd1;
  localparam logic [1:0] FILL   = 2'd2;
  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line, input logic [1:0] idx);
    return line[idx*WORD_W +: WORD_W];
  endfunction
endpackage

// File: rtl/icache_ctrl_if.sv
// icache_ctrl_if: fetch, cache array and memory signals seen by the icache controller
interface icache_ctrl_if;
  import icache_pkg::*;
  logic [15:0]       if_addr;
  logic              if_re;
  logic [WORD_W-1:0] instr;
  logic              i_rdy;
  logic              i_stall;
  logic [ADDR_W-1:0] c_addr;
  logic              c_re;
  logic              c_we;
  logic [LINE_W-1:0] c_wr_data;
  logic              c_wdirty;
  logic              c_hit;
  logic [LINE_W-1:0] c_rd_data;
  logic [ADDR_W-1:0] m_addr;
  logic              m_re;
  logic              m_rdy;
  logic [LINE_W-1:0] m_rd_data;
  modport master (
    input  if_addr, if_re, c_hit, c_rd_data, m_rdy, m_rd_data,
    output instr, i_rdy, i_stall, c_addr, c_re, c_we, c_wr_data, c_wdirty, m_addr, m_re
  );
  modport slave (
    output if_addr, if_re, c_hit, c_rd_data, m_rdy, m_rd_data,
    input  instr, i_rdy, i_stall, c_addr, c_re, c_we, c_wr_data, c_wdirty, m_addr, m_re
  );
endinterface

// File: rtl/icache_ctrl_line_word_mux.sv
// line_word_mux: picks one 16-bit word out of a 64-bit line
module line_word_mux
  import icache_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [1:0]        idx,
  output logic [WORD_W-1:0] word
);
  assign word = word_sel(line, idx);
endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped read-only icache miss controller with critical-word forward
module icache_ctrl
  import icache_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  icache_ctrl_if.master   bus
);
  logic [1:0]        state, nxt;
  logic [15:0]       miss_addr;
  logic [LINE_W-1:0] fill_buf;
  logic              kill, we_q, miss;
  logic [WORD_W-1:0] hit_word, fill_word;
  line_word_mux u_hit (.line(bus.c_rd_data), .idx(bus.if_addr[1:0]), .word(hit_word));
  line_word_mux u_fill (.line(fill_buf), .idx(miss_addr[1:0]), .word(fill_word));
  // next state: IDLE -> MEM_RD on miss, MEM_RD -> FILL on m_rdy, FILL always returns to IDLE
  always_comb begin
    miss = state == IDLE && bus.if_re && !bus.c_hit;
    nxt  = state == IDLE ? (miss ? MEM_RD : IDLE) :
           state == MEM_RD ? (bus.m_rdy ? FILL : MEM_RD) : IDLE;
  end
  // state, miss latch, fill buffer, flush kill flag and registered write strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      miss_addr <= '0;
      fill_buf  <= '0;
      kill      <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      state <= nxt;
      we_q  <= nxt == FILL;
      kill  <= state == MEM_RD && (kill || !bus.if_re);
      if (miss) miss_addr <= bus.if_addr;
      if (state == MEM_RD && bus.m_rdy) fill_buf <= bus.m_rd_data;
    end
  end
  // array, memory and fetch-side outputs decoded from state
  always_comb begin
    bus.c_addr    = state == IDLE ? bus.if_addr[15:2] : miss_addr[15:2];
    bus.c_re      = state == IDLE && bus.if_re;
    bus.c_we      = we_q;
    bus.c_wr_data = fill_buf;
    bus.c_wdirty  = 1'b0;
    bus.m_re      = state == MEM_RD;
    bus.m_addr    = miss_addr[15:2];
    bus.i_stall   = miss || state == MEM_RD;
    bus.i_rdy     = state == IDLE ? bus.if_re && bus.c_hit : state == FILL && !kill;
    bus.instr     = state == FILL ? fill_word : hit_word;
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: randomized and directed checks of icache_ctrl against a tag-level cache model
module tb_icache_ctrl;
  import icache_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  icache_ctrl_if bus();
  icache_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [7:0]  env_valid = 8'h00;
  logic [10:0] env_tag [8];
  logic [63:0] env_data [8];
  always_comb begin
    bus.c_hit     = env_valid[bus.c_addr[2:0]] && env_tag[bus.c_addr[2:0]] == bus.c_addr[13:3];
    bus.c_rd_data = env_data[bus.c_addr[2:0]];
  end
  always @(posedge clk) begin
    if (bus.c_we) begin
      env_valid[bus.c_addr[2:0]] <= 1'b1;
      env_tag[bus.c_addr[2:0]]   <= bus.c_addr[13:3];
      env_data[bus.c_addr[2:0]]  <= bus.c_wr_data;
    end
  end
  int errors = 0;
  int checks = 0;
  int last_stall;
  logic [63:0] last_fill = '0;
  logic [7:0]  ref_valid = 8'h00;
  logic [10:0] ref_tag [8];
  function automatic logic [63:0] mem_line(input logic [13:0] a);
    if (a == 14'h0001) return 64'h4444_3333_2222_1111;
    return {16'(a * 7 + 3), 16'(a * 13 + 1) ^ 16'hC3A5, 16'(a * 5) ^ 16'h0F0F, {2'b00, a} ^ 16'hA5A5};
  endfunction
  task automatic do_fetch(input logic [15:0] a, input int lat, input bit flush);
    logic [13:0] ln;
    logic [63:0] d;
    logic [15:0] w;
    bit hit;
    ln = a[15:2];
    d = mem_line(ln);
    w = d[a[1:0]*16 +: 16];
    hit = ref_valid[ln[2:0]] && ref_tag[ln[2:0]] == ln[13:3];
    last_stall = 0;
    @(negedge clk);
    bus.if_addr = a;
    bus.if_re = 1'b1;
    bus.m_rdy = 1'b0;
    #1;
    if (hit) begin
      checks++;
      if (bus.i_rdy !== 1'b1 || bus.instr !== w || bus.i_stall !== 1'b0 || bus.m_re !== 1'b0) begin
        errors++;
        $display("FAIL hit a=%h: rdy=%b instr=%h stall=%b m_re=%b, want rdy=1 instr=%h stall=0 m_re=0", a, bus.i_rdy, bus.instr, bus.i_stall, bus.m_re, w);
      end
      bus.if_re = 1'b0;
      return;
    end
    checks++;
    if (bus.i_stall !== 1'b1 || bus.i_rdy !== 1'b0 || bus.c_re !== 1'b1) begin
      errors++;
      $display("FAIL miss_detect a=%h: stall=%b rdy=%b c_re=%b, want 1 0 1", a, bus.i_stall, bus.i_rdy, bus.c_re);
    end
    last_stall += int'(bus.i_stall);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      if (flush && k == 0) bus.if_re = 1'b0;
      bus.m_rdy = k == lat - 1;
      bus.m_rd_data = bus.m_rdy ? d : {$urandom, $urandom};
      #1;
      checks++;
      if (bus.m_re !== 1'b1 || bus.m_addr !== ln || bus.i_stall !== 1'b1 || bus.c_we !== 1'b0 || bus.i_rdy !== 1'b0) begin
        errors++;
        $display("FAIL mem_rd a=%h k=%0d: m_re=%b m_addr=%h stall=%b c_we=%b rdy=%b, want 1 %h 1 0 0", a, k, bus.m_re, bus.m_addr, bus.i_stall, bus.c_we, bus.i_rdy, ln);
      end
      last_stall += int'(bus.i_stall);
    end
    @(negedge clk);
    bus.m_rdy = 1'b0;
    bus.m_rd_data = {$urandom, $urandom};
    #1;
    checks++;
    if (bus.c_we !== 1'b1 || bus.c_addr !== ln || bus.c_wr_data !== d || bus.c_re !== 1'b0 || bus.i_stall !== 1'b0 || bus.c_wdirty !== 1'b0) begin
      errors++;
      $display("FAIL fill_write a=%h: c_we=%b c_addr=%h data=%h c_re=%b stall=%b dirty=%b, want 1 %h %h 0 0 0", a, bus.c_we, bus.c_addr, bus.c_wr_data, bus.c_re, bus.i_stall, bus.c_wdirty, ln, d);
    end
    checks++;
    if (bus.i_rdy !== (flush ? 1'b0 : 1'b1) || (!flush && bus.instr !== w)) begin
      errors++;
      $display("FAIL fill_fwd a=%h flush=%0d: rdy=%b instr=%h, want rdy=%b instr=%h", a, flush, bus.i_rdy, bus.instr, !flush, w);
    end
    ref_valid[ln[2:0]] = 1'b1;
    ref_tag[ln[2:0]] = ln[13:3];
    last_fill = d;
    bus.if_re = 1'b0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if ({bus.i_rdy, bus.i_stall, bus.c_we, bus.c_re, bus.m_re} !== 5'b0 || bus.c_wr_data !== 64'h0 || bus.m_addr !== 14'h0) begin
      errors++;
      $display("FAIL reset: rdy/stall/we/re/m_re=%b wr_data=%h m_addr=%h, want 00000 0 0", {bus.i_rdy, bus.i_stall, bus.c_we, bus.c_re, bus.m_re}, bus.c_wr_data, bus.m_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.i_rdy, bus.i_stall, bus.c_we, bus.m_re} !== 4'b0) begin
      errors++;
      $display("FAIL post_reset_idle: rdy/stall/we/m_re=%b, want 0000", {bus.i_rdy, bus.i_stall, bus.c_we, bus.m_re});
    end
  endtask
  task automatic test_cold_miss();
    do_fetch(16'h0005, 2, 1'b0);
    checks++;
    if (last_stall != 3) begin
      errors++;
      $display("FAIL cold_miss_stall: stall cycles=%0d, want 3", last_stall);
    end
  endtask
  task automatic test_hit();
    do_fetch(16'h0007, 1, 1'b0);
    checks++;
    if (last_stall != 0) begin
      errors++;
      $display("FAIL hit_stall: stall cycles=%0d, want 0", last_stall);
    end
  endtask
  task automatic test_conflict();
    do_fetch(16'h0025, 1, 1'b0);
    do_fetch(16'h0005, 1, 1'b0);
    do_fetch(16'h0006, 1, 1'b0);
  endtask
  task automatic test_flush();
    do_fetch(16'h0042, 2, 1'b1);
    do_fetch(16'h0042, 1, 1'b0);
    do_fetch(16'h0043, 1, 1'b0);
  endtask
  task automatic test_reset_mid_miss();
    @(negedge clk);
    bus.if_addr = 16'h0100;
    bus.if_re = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.m_re !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: m_re=%b, want 1", bus.m_re);
    end
    rst_n = 1'b0;
    bus.if_re = 1'b0;
    #1;
    checks++;
    if (bus.m_re !== 1'b0 || bus.c_we !== 1'b0 || bus.i_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_drop: m_re=%b c_we=%b stall=%b, want 0 0 0", bus.m_re, bus.c_we, bus.i_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.m_rdy = 1'b1;
    bus.m_rd_data = mem_line(14'h0040);
    #1;
    checks++;
    if (bus.c_we !== 1'b0 || bus.i_rdy !== 1'b0) begin
      errors++;
      $display("FAIL rst_late_rdy: c_we=%b rdy=%b, want 0 0", bus.c_we, bus.i_rdy);
    end
    @(negedge clk);
    bus.m_rdy = 1'b0;
    #1;
    checks++;
    if (bus.c_we !== 1'b0 || bus.c_wr_data !== 64'h0) begin
      errors++;
      $display("FAIL rst_no_fill: c_we=%b wr_data=%h, want 0 0", bus.c_we, bus.c_wr_data);
    end
    last_fill = '0;
    do_fetch(16'h0100, 1, 1'b0);
  endtask
  task automatic test_spurious_rdy();
    @(negedge clk);
    bus.if_re = 1'b0;
    bus.m_rdy = 1'b1;
    bus.m_rd_data = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    checks++;
    if (bus.c_we !== 1'b0 || bus.i_rdy !== 1'b0 || bus.m_re !== 1'b0) begin
      errors++;
      $display("FAIL spurious_idle: c_we=%b rdy=%b m_re=%b, want 0 0 0", bus.c_we, bus.i_rdy, bus.m_re);
    end
    @(negedge clk);
    bus.m_rdy = 1'b0;
    #1;
    checks++;
    if (bus.c_we !== 1'b0 || bus.c_wr_data !== last_fill) begin
      errors++;
      $display("FAIL spurious_buf: c_we=%b wr_data=%h, want 0 %h", bus.c_we, bus.c_wr_data, last_fill);
    end
    do_fetch(16'h0007, 1, 1'b0);
  endtask
  task automatic test_back_to_back();
    do_fetch(16'h0200, 1, 1'b0);
    do_fetch(16'h0305, 1, 1'b0);
    do_fetch(16'h0200, 1, 1'b0);
    do_fetch(16'h0306, 1, 1'b0);
    do_fetch(16'h0201, 1, 1'b0);
  endtask
  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      do_fetch(16'($urandom_range(0, 3) * 32 + $urandom_range(0, 7) * 4 + $urandom_range(0, 3)),
               int'($urandom_range(1, 3)), $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask
  initial begin
    bus.if_addr = '0;
    bus.if_re = 1'b0;
    bus.m_rdy = 1'b0;
    bus.m_rd_data = '0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush();
    test_reset_mid_miss();
    test_spurious_rdy();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
